// File: rtl/pcd8544_pkg.sv
// rtl/pcd8544_pkg.sv - state encoding, timing defaults and PCD8544 command bytes
package pcd8544_pkg;

  typedef enum logic [2:0] {
    LCD_RST,
    IDLE,
    LOAD,
    SHIFT,
    DONE,
    GAP
  } state_t;

  localparam int DEF_RST_CYCLES = 16;
  localparam int DEF_GAP_CYCLES = 2;

  localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
  localparam logic [7:0] CMD_SET_VOP     = 8'h90;
  localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
  localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
  localparam logic [7:0] CMD_SET_X_BASE  = 8'h80;
  localparam logic [7:0] CMD_SET_Y_BASE  = 8'h40;

  // A zero divider would stall the tick generator, so it runs at the fastest rate.
  function automatic logic [15:0] half_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - half-period tick generator for the SPI serial clock
module spi_tick_gen (
  input  logic        clock,
  input  logic        Reset,
  input  logic        en,
  input  logic [15:0] half,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = en && (cnt == half - 16'd1);

  always_ff @(posedge clock) begin
    if (Reset || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pcd8544_spi_tx.sv
// rtl/pcd8544_spi_tx.sv - PCD8544 LCD serial transmitter (SPI mode 0, MSB first)
module pcd8544_spi_tx
  import pcd8544_pkg::*;
#(
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [7:0]  data_in,
  input  logic        start,
  input  logic        command,
  input  logic [15:0] div_factor,
  output logic        mosi,
  output logic        sclk,
  output logic        sce,
  output logic        dc,
  output logic        rst,
  output logic        busy,
  output logic        avail
);

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] half;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        tick;
  logic        shift_en;
  logic        gap_last;
  logic        take;

  // The LOAD cycle is the first cycle of the first low half-period, which
  // keeps a byte at exactly sixteen half-periods from LOAD to DONE.
  assign shift_en = (state == LOAD) || (state == SHIFT);
  assign gap_last = (int'(cnt) >= GAP_CYCLES - 1);
  assign take     = start && ((state == IDLE) || ((state == GAP) && gap_last));

  spi_tick_gen u_tick_gen (
    .clock (clock),
    .Reset (Reset),
    .en    (shift_en),
    .half  (half),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      state   <= LCD_RST;
      mosi    <= 1'b0;
      sclk    <= 1'b0;
      sce     <= 1'b1;
      dc      <= 1'b0;
      rst     <= 1'b0;
      busy    <= 1'b1;
      avail   <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      half    <= 16'd1;
    end else begin
      avail <= 1'b0;
      case (state)
        LCD_RST: begin
          // rst rises after the hold; busy drops one cycle later on entering IDLE.
          if (!rst) begin
            if (cnt == RST_LAST) rst <= 1'b1;
            cnt <= cnt + 16'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          sce  <= 1'b1;
          sclk <= 1'b0;
          if (start) state <= LOAD;
        end
        LOAD, SHIFT: begin
          state <= SHIFT;
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                state <= DONE;
                avail <= 1'b1;
                mosi  <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                mosi    <= shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
              end
            end
          end
        end
        DONE: begin
          state <= GAP;
          cnt   <= '0;
        end
        GAP: begin
          if (gap_last) begin
            if (start) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              sce   <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= LCD_RST;
      endcase

      // Byte latch on entry to LOAD so LOAD already presents sce low and bit 7.
      if (take) begin
        shreg   <= data_in;
        dc      <= command;
        half    <= half_period(div_factor);
        sce     <= 1'b0;
        mosi    <= data_in[7];
        bit_cnt <= '0;
        busy    <= 1'b1;
      end
    end
  end

endmodule
